// File: rtl/taxi_i2c_pkg.sv
// Shared definitions for the I2C master and its register-access front end.
//   - command word bit positions (12-bit command stream to the master)
//   - build_cmd(): assembles a command word from its fields
//   - reg_state_t: state encoding of the register-access sequencer
package taxi_i2c_pkg;

    localparam int unsigned CMD_W           = 12;
    localparam int unsigned CMD_ADDR_LSB    = 0;
    localparam int unsigned CMD_START_BIT   = 7;
    localparam int unsigned CMD_READ_BIT    = 8;
    localparam int unsigned CMD_WRITE_BIT   = 9;
    localparam int unsigned CMD_WR_MULT_BIT = 10;
    localparam int unsigned CMD_STOP_BIT    = 11;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StRdCmd,
        StRdWait,
        StWaitDone,
        StRsp
    } reg_state_t;

    function automatic logic [CMD_W-1:0] build_cmd(
        input logic [6:0] dev,
        input logic       start,
        input logic       read,
        input logic       write,
        input logic       wr_mult,
        input logic       stop
    );
        logic [CMD_W-1:0] c;
        c                      = '0;
        c[CMD_ADDR_LSB +: 7]   = dev;
        c[CMD_START_BIT]       = start;
        c[CMD_READ_BIT]        = read;
        c[CMD_WRITE_BIT]       = write;
        c[CMD_WR_MULT_BIT]     = wr_mult;
        c[CMD_STOP_BIT]        = stop;
        return c;
    endfunction

endpackage

// File: rtl/taxi_i2c_reg_access.sv
// Register-access sequencer in front of the I2C master.
// Turns one register read/write request into command and data streams for the master and
// returns exactly one response per request.
//   write: START+dev (write-multiple, STOP) -> reg addr bytes (MSB first) -> wr_data
//   read : START+dev (write-multiple)       -> reg addr bytes, then repeated START read of 1 byte
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    request channel (valid/ready), fields registered on accept
//   rsp_*                    response channel, held until rsp_ready
//   m_axis_cmd_*             12-bit command stream to the master (taxi_axis_if fields, no keep/last)
//   m_axis_data_*            write-data stream to the master, tlast on the final byte
//   s_axis_data_*            read-data stream from the master
//   i2c_busy, i2c_missed_ack master status
//
// Parameters
//   REG_ADDR_W      8 or 16 (one or two register address bytes)
//   TIMEOUT_CYCLES  per-request cycle budget, only used with TAXI_I2C_REG_TIMEOUT_EN
//
// Build option
//   TAXI_I2C_REG_TIMEOUT_EN  adds a per-request watchdog that forces an error response.
//   Without it a hung bus stalls the block until rst.
module taxi_i2c_reg_access
    import taxi_i2c_pkg::*;
#(
    parameter int unsigned REG_ADDR_W     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_read,
    input  logic [6:0]            req_dev_addr,
    input  logic [REG_ADDR_W-1:0] req_reg_addr,
    input  logic [7:0]            req_wr_data,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_rd_data,
    output logic                  rsp_err,

    output logic [CMD_W-1:0]      m_axis_cmd_tdata,
    output logic                  m_axis_cmd_tvalid,
    input  logic                  m_axis_cmd_tready,

    output logic [7:0]            m_axis_data_tdata,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready,
    output logic                  m_axis_data_tlast,

    input  logic [7:0]            s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,

    input  logic                  i2c_busy,
    input  logic                  i2c_missed_ack
);

    localparam int unsigned ADDR_BYTES    = REG_ADDR_W / 8;
    localparam logic [1:0]  LAST_ADDR_IDX = 2'(ADDR_BYTES - 1);

    reg_state_t            state_q, state_d;
    logic                  req_ready_q;
    logic                  read_q, read_d;
    logic [6:0]            dev_q, dev_d;
    logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic                  err_q, err_d;
    logic [7:0]            rd_data_q, rd_data_d;

    logic                  accept;
    logic                  data_last;
    logic [7:0]            data_byte;

`ifdef TAXI_I2C_REG_TIMEOUT_EN
    logic [31:0]           timer_q, timer_d;
`else
    logic                  unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Registered so that req_ready stays low while rst is held and rises one cycle after
    // the response handshake.
    assign req_ready = req_ready_q;
    assign accept    = (state_q == StIdle) && req_valid && req_ready_q;

    // Reads send only the address bytes; writes append the data byte.
    assign data_last = (byte_idx_q == (read_q ? LAST_ADDR_IDX : LAST_ADDR_IDX + 2'd1));

    always_comb begin
        data_byte = wr_data_q;
        for (int unsigned i = 0; i < ADDR_BYTES; i++) begin
            if (byte_idx_q == 2'(i)) begin
                data_byte = reg_addr_q[8*(ADDR_BYTES-1-i) +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        read_d     = read_q;
        dev_d      = dev_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        byte_idx_d = byte_idx_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;

        // A NACK in the accept cycle belongs to the previous request and is ignored.
        if (state_q != StIdle && i2c_missed_ack) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    read_d     = req_read;
                    dev_d      = req_dev_addr;
                    reg_addr_d = req_reg_addr;
                    wr_data_d  = req_wr_data;
                    byte_idx_d = 2'd0;
                    err_d      = 1'b0;
                    rd_data_d  = 8'h00;
                    state_d    = StCmd;
                end
            end
            StCmd: begin
                if (m_axis_cmd_tready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (m_axis_data_tready) begin
                    if (data_last) begin
                        state_d = read_q ? StRdCmd : StWaitDone;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StRdCmd: begin
                if (m_axis_cmd_tready) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (s_axis_data_tvalid) begin
                    rd_data_d = s_axis_data_tdata;
                    state_d   = StWaitDone;
                end else if (!i2c_busy && err_q) begin
                    // Master abandoned the read after a NACK; no data beat will come.
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!i2c_busy) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef TAXI_I2C_REG_TIMEOUT_EN
        timer_d = timer_q;
        if (accept) begin
            timer_d = TIMEOUT_CYCLES;
        end else if (state_q != StIdle && state_q != StRsp) begin
            if (timer_q == 32'd0) begin
                // Leaving the active states drops every tvalid; late master data is
                // swallowed by the always-ready sink in IDLE.
                state_d = StRsp;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q - 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            read_q      <= 1'b0;
            dev_q       <= '0;
            reg_addr_q  <= '0;
            wr_data_q   <= '0;
            byte_idx_q  <= '0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == StIdle);
            read_q      <= read_d;
            dev_q       <= dev_d;
            reg_addr_q  <= reg_addr_d;
            wr_data_q   <= wr_data_d;
            byte_idx_q  <= byte_idx_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
        end
    end

`ifdef TAXI_I2C_REG_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_comb begin
        m_axis_cmd_tvalid = (state_q == StCmd) || (state_q == StRdCmd);
        if (state_q == StRdCmd) begin
            m_axis_cmd_tdata = build_cmd(dev_q, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        end else begin
            // Reads keep the bus (no STOP) for the repeated START that follows.
            m_axis_cmd_tdata = build_cmd(dev_q, 1'b1, 1'b0, 1'b0, 1'b1, !read_q);
        end

        m_axis_data_tvalid = (state_q == StData);
        m_axis_data_tdata  = data_byte;
        m_axis_data_tlast  = data_last;

        s_axis_data_tready = (state_q == StIdle) || (state_q == StRdWait);

        rsp_valid   = (state_q == StRsp);
        rsp_err     = err_q;
        rsp_rd_data = (state_q == StRsp && !err_q) ? rd_data_q : 8'h00;
    end

endmodule

// File: tb/tb_taxi_i2c_reg_access.sv
// Directed bench for taxi_i2c_reg_access: an 8-bit-address instance (index 0) and a
// 16-bit-address instance (index 1), each driven by a small behavioural I2C master model.
module tb_taxi_i2c_reg_access;

    localparam logic [6:0] ABSENT_DEV = 7'h21;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        req_valid[2], req_ready[2], req_read[2];
    logic [6:0]  req_dev_addr[2];
    logic [15:0] req_reg_addr[2];
    logic [7:0]  req_wr_data[2];
    logic        rsp_valid[2], rsp_ready[2], rsp_err[2];
    logic [7:0]  rsp_rd_data[2];
    logic [11:0] cmd_tdata[2];
    logic        cmd_tvalid[2], cmd_tready[2];
    logic [7:0]  dat_tdata[2];
    logic        dat_tvalid[2], dat_tready[2], dat_tlast[2];
    logic [7:0]  s_tdata[2];
    logic        s_tvalid[2], s_tready[2];
    logic        busy[2], miss_ack[2];

    taxi_i2c_reg_access #(.REG_ADDR_W(8), .TIMEOUT_CYCLES(100)) u_dut8 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_read(req_read[0]),
        .req_dev_addr(req_dev_addr[0]), .req_reg_addr(req_reg_addr[0][7:0]),
        .req_wr_data(req_wr_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rd_data(rsp_rd_data[0]),
        .rsp_err(rsp_err[0]),
        .m_axis_cmd_tdata(cmd_tdata[0]), .m_axis_cmd_tvalid(cmd_tvalid[0]),
        .m_axis_cmd_tready(cmd_tready[0]),
        .m_axis_data_tdata(dat_tdata[0]), .m_axis_data_tvalid(dat_tvalid[0]),
        .m_axis_data_tready(dat_tready[0]), .m_axis_data_tlast(dat_tlast[0]),
        .s_axis_data_tdata(s_tdata[0]), .s_axis_data_tvalid(s_tvalid[0]),
        .s_axis_data_tready(s_tready[0]),
        .i2c_busy(busy[0]), .i2c_missed_ack(miss_ack[0])
    );

    taxi_i2c_reg_access #(.REG_ADDR_W(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_read(req_read[1]),
        .req_dev_addr(req_dev_addr[1]), .req_reg_addr(req_reg_addr[1]),
        .req_wr_data(req_wr_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rd_data(rsp_rd_data[1]),
        .rsp_err(rsp_err[1]),
        .m_axis_cmd_tdata(cmd_tdata[1]), .m_axis_cmd_tvalid(cmd_tvalid[1]),
        .m_axis_cmd_tready(cmd_tready[1]),
        .m_axis_data_tdata(dat_tdata[1]), .m_axis_data_tvalid(dat_tvalid[1]),
        .m_axis_data_tready(dat_tready[1]), .m_axis_data_tlast(dat_tlast[1]),
        .s_axis_data_tdata(s_tdata[1]), .s_axis_data_tvalid(s_tvalid[1]),
        .s_axis_data_tready(s_tready[1]),
        .i2c_busy(busy[1]), .i2c_missed_ack(miss_ack[1])
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave register contents seen through the master: value = low address byte + 0x26.
    function automatic logic [7:0] slave_rd(input logic [7:0] r);
        return r + 8'h26;
    endfunction

    // 0: always ready, 1: random, 2: stuck low
    function automatic logic pick(input int m);
        if (m == 0) return 1'b1;
        if (m == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // ---------------- master model (acts on negedge, blocking) ----------------
    int unsigned busy_cnt[2], miss_pend[2], rd_pend[2];
    bit          nacked[2], stop_after_data[2], s_hs[2], stall_c[2], stall_d[2];
    logic [11:0] prev_c[2];
    logic [8:0]  prev_d[2];
    logic [7:0]  last_data[2];
    int          cmd_mode[2], dat_mode[2];
    bit          chk_stable;
    logic [11:0] cmd_log[$];
    logic [8:0]  data_log[$];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k] = 0; miss_ack[k] = 0; s_tvalid[k] = 0; s_tdata[k] = 0;
                busy_cnt[k] = 0; miss_pend[k] = 0; rd_pend[k] = 0; nacked[k] = 0;
                stop_after_data[k] = 0; s_hs[k] = 0; stall_c[k] = 0; stall_d[k] = 0;
                cmd_tready[k] = 0; dat_tready[k] = 0; last_data[k] = 0;
            end else begin
                miss_ack[k] = 0;
                if (miss_pend[k] != 0) begin
                    miss_pend[k]--;
                    if (miss_pend[k] == 0) miss_ack[k] = 1;
                end
                if (busy_cnt[k] != 0) begin
                    busy_cnt[k]--;
                    if (busy_cnt[k] == 0) busy[k] = 0;
                end
                if (rd_pend[k] != 0) begin
                    rd_pend[k]--;
                    if (rd_pend[k] == 0) begin
                        s_tvalid[k] = 1;
                        s_tdata[k]  = slave_rd(last_data[k]);
                    end
                end
                if (s_hs[k]) begin
                    s_hs[k] = 0; s_tvalid[k] = 0; busy_cnt[k] = 3;
                end else if (s_tvalid[k] && s_tready[k]) begin
                    s_hs[k] = 1;
                end
                if (chk_stable && stall_c[k])
                    chk("cmd_hold", {19'b0, cmd_tvalid[k], cmd_tdata[k]}, {19'b0, 1'b1, prev_c[k]});
                if (chk_stable && stall_d[k])
                    chk("data_hold", {22'b0, dat_tvalid[k], dat_tlast[k], dat_tdata[k]},
                        {22'b0, 1'b1, prev_d[k]});
                cmd_tready[k] = pick(cmd_mode[k]);
                dat_tready[k] = pick(dat_mode[k]);
                stall_c[k] = cmd_tvalid[k] && !cmd_tready[k];
                prev_c[k]  = cmd_tdata[k];
                stall_d[k] = dat_tvalid[k] && !dat_tready[k];
                prev_d[k]  = {dat_tlast[k], dat_tdata[k]};
                if (cmd_tvalid[k] && cmd_tready[k]) begin
                    cmd_log.push_back(cmd_tdata[k]);
                    busy[k] = 1; busy_cnt[k] = 0;
                    if (!cmd_tdata[k][8]) begin
                        nacked[k] = (cmd_tdata[k][6:0] == ABSENT_DEV);
                        stop_after_data[k] = cmd_tdata[k][11];
                        if (nacked[k]) miss_pend[k] = 2;
                    end else if (nacked[k]) begin
                        busy_cnt[k] = 4;
                    end else begin
                        rd_pend[k] = 2;
                    end
                end
                if (dat_tvalid[k] && dat_tready[k]) begin
                    data_log.push_back({dat_tlast[k], dat_tdata[k]});
                    last_data[k] = dat_tdata[k];
                    if (dat_tlast[k] && stop_after_data[k]) busy_cnt[k] = 3;
                end
            end
        end
    end

    // ---------------- one request/response with stream checks ----------------
    task automatic run_txn(input int k, input bit rd, input logic [6:0] dev,
                           input logic [15:0] ra, input logic [7:0] wd, input bit rand_rsp,
                           input logic [7:0] exp_rd, input logic exp_err);
        logic [7:0]  got_rd;
        logic        got_err;
        int          n;
        logic [11:0] exp_cmd[$];
        logic [8:0]  exp_dat[$];
        cmd_log.delete();
        data_log.delete();
        req_valid[k] = 1; req_read[k] = rd; req_dev_addr[k] = dev;
        req_reg_addr[k] = ra; req_wr_data[k] = wd;
        n = 0;
        while (!req_ready[k] && n < 100) begin @(negedge clk); n++; end
        chk("req_accept", 32'(n < 100), 32'd1);
        @(negedge clk);
        req_valid[k] = 0;
        n = 0;
        forever begin
            rsp_ready[k] = rand_rsp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid[k] && rsp_ready[k]) break;
            if (n == 5000) break;
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 32'(n < 5000), 32'd1);
        got_rd  = rsp_rd_data[k];
        got_err = rsp_err[k];
        @(negedge clk);
        rsp_ready[k] = 0;
        chk("req_ready_b2b", 32'(req_ready[k]), 32'd1);
        chk("rsp_err", 32'(got_err), 32'(exp_err));
        chk("rsp_rd_data", 32'(got_rd), 32'(exp_rd));
        if (rd) begin
            exp_cmd.push_back(12'h480 | {5'b0, dev});
            exp_cmd.push_back(12'h980 | {5'b0, dev});
        end else begin
            exp_cmd.push_back(12'hC80 | {5'b0, dev});
        end
        if (k == 1) exp_dat.push_back({1'b0, ra[15:8]});
        exp_dat.push_back({rd, ra[7:0]});
        if (!rd) exp_dat.push_back({1'b1, wd});
        chk("cmd_count", 32'(cmd_log.size()), 32'(exp_cmd.size()));
        for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++)
            chk("cmd_word", 32'(cmd_log[i]), 32'(exp_cmd[i]));
        chk("data_count", 32'(data_log.size()), 32'(exp_dat.size()));
        for (int i = 0; i < exp_dat.size() && i < data_log.size(); i++)
            chk("data_beat", 32'(data_log[i]), 32'(exp_dat[i]));
    endtask

    int          n_wait;
    bit          r_rd;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg, r_wd;

    initial begin
        rst = 1;
        chk_stable = 0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_read[k] = 0; req_dev_addr[k] = 0; req_reg_addr[k] = 0;
            req_wr_data[k] = 0; rsp_ready[k] = 0; cmd_mode[k] = 0; dat_mode[k] = 0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_rd_data", 32'(rsp_rd_data[0]), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
        chk("rst_cmd_tvalid", 32'(cmd_tvalid[0]), 32'd0);
        chk("rst_data_tvalid", 32'(dat_tvalid[0]), 32'd0);
        chk("rst_s_tready", 32'(s_tready[0]), 32'd1);
        rst = 0;
        @(negedge clk);
        chk("req_ready_post_rst", 32'(req_ready[0]), 32'd1);

        // 1: write dev 0x50 reg 0x12 data 0xA5
        run_txn(0, 0, 7'h50, 16'h0012, 8'hA5, 0, 8'h00, 1'b0);
        chk("t1_cmd", 32'(cmd_log[0]), 32'hCD0);
        chk("t1_d0", 32'(data_log[0]), 32'h012);
        chk("t1_d1_last", 32'(data_log[1]), 32'h1A5);

        // 2: read dev 0x50 reg 0x34, slave returns 0x5A
        run_txn(0, 1, 7'h50, 16'h0034, 8'h00, 0, 8'h5A, 1'b0);
        chk("t2_cmd0", 32'(cmd_log[0]), 32'h4D0);
        chk("t2_cmd1", 32'(cmd_log[1]), 32'h9D0);
        chk("t2_d0_last", 32'(data_log[0]), 32'h134);

        // 3: 16-bit register address
        run_txn(1, 0, 7'h50, 16'hBEEF, 8'h01, 0, 8'h00, 1'b0);
        chk("t3_d0", 32'(data_log[0]), 32'h0BE);
        chk("t3_d1", 32'(data_log[1]), 32'h0EF);
        chk("t3_d2_last", 32'(data_log[2]), 32'h101);
        run_txn(1, 1, 7'h50, 16'h1234, 8'h00, 0, 8'h5A, 1'b0);

        // 4: absent device, write then read, then a normal request
        run_txn(0, 0, ABSENT_DEV, 16'h0007, 8'h33, 0, 8'h00, 1'b1);
        chk("t4_cmd", 32'(cmd_log[0]), 32'hCA1);
        run_txn(0, 1, ABSENT_DEV, 16'h0040, 8'h00, 0, 8'h00, 1'b1);
        run_txn(0, 0, 7'h50, 16'h0013, 8'h5C, 0, 8'h00, 1'b0);

        // 5: random backpressure, 50 mixed requests
        cmd_mode[0] = 1; dat_mode[0] = 1; chk_stable = 1;
        for (int i = 0; i < 50; i++) begin
            r_rd  = 1'($urandom_range(0, 1));
            r_dev = 7'h50 + 7'($urandom_range(0, 3));
            r_reg = 8'($urandom_range(0, 255));
            r_wd  = 8'($urandom_range(0, 255));
            run_txn(0, r_rd, r_dev, {8'h00, r_reg}, r_wd, 1,
                    r_rd ? slave_rd(r_reg) : 8'h00, 1'b0);
        end
        chk_stable = 0; cmd_mode[0] = 0; dat_mode[0] = 0;
        @(negedge clk);

`ifdef TAXI_I2C_REG_TIMEOUT_EN
        // 6a: command never accepted -> error response after the budget
        cmd_mode[0] = 2;
        @(negedge clk);
        cmd_log.delete();
        req_valid[0] = 1; req_read[0] = 0; req_dev_addr[0] = 7'h50;
        req_reg_addr[0] = 16'h0001; req_wr_data[0] = 8'h02;
        n_wait = 0;
        while (!req_ready[0] && n_wait < 100) begin @(negedge clk); n_wait++; end
        @(negedge clk);
        req_valid[0] = 0;
        n_wait = 0;
        while (!rsp_valid[0] && n_wait < 300) begin @(negedge clk); n_wait++; end
        chk("timeout_cycles", 32'(n_wait), 32'd101);
        chk("timeout_err", 32'(rsp_err[0]), 32'd1);
        chk("timeout_rd", 32'(rsp_rd_data[0]), 32'd0);
        chk("timeout_cmd_drop", 32'(cmd_tvalid[0]), 32'd0);
        chk("timeout_no_cmd", 32'(cmd_log.size()), 32'd0);
        rsp_ready[0] = 1;
        @(negedge clk);
        rsp_ready[0] = 0;
        cmd_mode[0] = 0;
        @(negedge clk);
`endif

        // 6b: reset in the middle of the data phase
        dat_mode[0] = 2;
        req_valid[0] = 1; req_read[0] = 0; req_dev_addr[0] = 7'h50;
        req_reg_addr[0] = 16'h0055; req_wr_data[0] = 8'h66;
        n_wait = 0;
        while (!req_ready[0] && n_wait < 100) begin @(negedge clk); n_wait++; end
        @(negedge clk);
        req_valid[0] = 0;
        n_wait = 0;
        while (!dat_tvalid[0] && n_wait < 100) begin @(negedge clk); n_wait++; end
        chk("mid_data_reached", 32'(dat_tvalid[0]), 32'd1);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(req_ready[0]), 32'd0);
        chk("mid_rst_data_tvalid", 32'(dat_tvalid[0]), 32'd0);
        chk("mid_rst_cmd_tvalid", 32'(cmd_tvalid[0]), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        rst = 0;
        dat_mode[0] = 0;
        @(negedge clk);
        chk("mid_rst_ready_after", 32'(req_ready[0]), 32'd1);
        run_txn(0, 1, 7'h50, 16'h0010, 8'h00, 0, 8'h36, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
